// File: rtl/exec_operand_stage.sv
// Decode-to-execute operand stage: captures decoded ops, forwards writeback data
// onto source operands and presents them to the ALU through a 2-entry skid buffer.
module exec_operand_stage #(
  parameter int ALU_OP   = 4,
  parameter int REG_ADDR = 5,
  parameter int DATA     = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP-1:0]   in_alu_op,
  input  logic [REG_ADDR-1:0] in_dest,
  input  logic [REG_ADDR-1:0] in_srcA_reg,
  input  logic [REG_ADDR-1:0] in_srcB_reg,
  input  logic [DATA-1:0]     in_srcA_val,
  input  logic [DATA-1:0]     in_srcB_val,
  input  logic                in_use_imm,
  input  logic [DATA-1:0]     in_imm,
  input  logic                fwd_valid,
  input  logic [REG_ADDR-1:0] fwd_reg,
  input  logic [DATA-1:0]     fwd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP-1:0]   out_alu_op,
  output logic [DATA-1:0]     out_srcA,
  output logic [DATA-1:0]     out_srcB,
  output logic [REG_ADDR-1:0] out_dest
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and in_ready is a register.

  typedef struct packed {
    logic                valid;
    logic                use_imm;
    logic [ALU_OP-1:0]   op;
    logic [REG_ADDR-1:0] dest;
    logic [REG_ADDR-1:0] a_reg;
    logic [REG_ADDR-1:0] b_reg;
    logic [DATA-1:0]     a;
    logic [DATA-1:0]     b;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  entry_t cap;
  entry_t main_snp;
  entry_t skid_snp;
  logic   accept;
  logic   fire;
  logic   main_free;

  // Register 0 is hard-wired zero, so it is never a forwarding target.
  function automatic logic fwd_hit(input logic                fv,
                                   input logic [REG_ADDR-1:0] fr,
                                   input logic [REG_ADDR-1:0] r);
    return fv && (fr == r) && (r != '0);
  endfunction

  function automatic entry_t snoop(input entry_t                e,
                                   input logic                  fv,
                                   input logic [REG_ADDR-1:0]   fr,
                                   input logic [DATA-1:0]       fd);
    entry_t s;
    s = e;
    if (e.valid) begin
      if (fwd_hit(fv, fr, e.a_reg)) s.a = fd;
      if (!e.use_imm && fwd_hit(fv, fr, e.b_reg)) s.b = fd;
    end
    return s;
  endfunction

  always_comb begin
    cap         = '0;
    cap.valid   = 1'b1;
    cap.use_imm = in_use_imm;
    cap.op      = in_alu_op;
    cap.dest    = in_dest;
    cap.a_reg   = in_srcA_reg;
    cap.b_reg   = in_srcB_reg;
    cap.a       = fwd_hit(fwd_valid, fwd_reg, in_srcA_reg) ? fwd_data : in_srcA_val;
    if (in_use_imm)
      cap.b = in_imm;
    else
      cap.b = fwd_hit(fwd_valid, fwd_reg, in_srcB_reg) ? fwd_data : in_srcB_val;
  end

  assign main_snp  = snoop(main_q, fwd_valid, fwd_reg, fwd_data);
  assign skid_snp  = snoop(skid_q, fwd_valid, fwd_reg, fwd_data);
  assign accept    = in_valid & in_ready_q;
  assign fire      = main_q.valid & out_ready;
  assign main_free = !main_q.valid || fire;

  // A firing MAIN entry is leaving, so it takes no snoop; SKID always does,
  // including on the edge where it is promoted into MAIN.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (main_free) begin
      if (skid_q.valid) begin
        main_d = skid_snp;
        if (accept) skid_d = cap;
        else        skid_d.valid = 1'b0;
      end else begin
        if (accept) main_d = cap;
        else        main_d.valid = 1'b0;
      end
    end else begin
      main_d = main_snp;
      if (accept) skid_d = cap;
      else        skid_d = skid_snp;
    end
    in_ready_d = !skid_d.valid;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_q.valid;
  assign out_alu_op = main_q.op;
  assign out_srcA   = main_q.a;
  assign out_srcB   = main_q.b;
  assign out_dest   = main_q.dest;

endmodule

// File: tb/tb_exec_operand_stage.sv
// Directed bench for exec_operand_stage: hand-computed expectations for flow,
// stalls, capture/snoop forwarding, flush and asynchronous reset.
module tb_exec_operand_stage;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_dest;
  logic [4:0]  in_srcA_reg;
  logic [4:0]  in_srcB_reg;
  logic [31:0] in_srcA_val;
  logic [31:0] in_srcB_val;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_srcA;
  logic [31:0] out_srcB;
  logic [4:0]  out_dest;

  int tests_run;
  int tests_failed;

  exec_operand_stage #(.ALU_OP(4), .REG_ADDR(5), .DATA(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_op   (in_alu_op),
    .in_dest     (in_dest),
    .in_srcA_reg (in_srcA_reg),
    .in_srcB_reg (in_srcB_reg),
    .in_srcA_val (in_srcA_val),
    .in_srcB_val (in_srcB_val),
    .in_use_imm  (in_use_imm),
    .in_imm      (in_imm),
    .fwd_valid   (fwd_valid),
    .fwd_reg     (fwd_reg),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_srcA    (out_srcA),
    .out_srcB    (out_srcB),
    .out_dest    (out_dest)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_alu_op   = '0;
    in_dest     = '0;
    in_srcA_reg = '0;
    in_srcB_reg = '0;
    in_srcA_val = '0;
    in_srcB_val = '0;
    in_use_imm  = 1'b0;
    in_imm      = '0;
    fwd_valid   = 1'b0;
    fwd_reg     = '0;
    fwd_data    = '0;
    flush       = 1'b0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [4:0] dest,
                          input logic [4:0] ar, input logic [31:0] av,
                          input logic [4:0] br, input logic [31:0] bv,
                          input logic ui, input logic [31:0] imm);
    in_valid    = 1'b1;
    in_alu_op   = op;
    in_dest     = dest;
    in_srcA_reg = ar;
    in_srcA_val = av;
    in_srcB_reg = br;
    in_srcB_val = bv;
    in_use_imm  = ui;
    in_imm      = imm;
  endtask

  task automatic drive_fwd(input logic v, input logic [4:0] r, input logic [31:0] d);
    fwd_valid = v;
    fwd_reg   = r;
    fwd_data  = d;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_srcA", out_srcA, 0);
    check("rst_alu_op", out_alu_op, 0);
    reset_n = 1'b1;
    step();

    // single add, then 4 back-to-back ops at one per cycle
    out_ready = 1'b1;
    drive_op(4'd6, 5'd4, 5'd1, 32'd5, 5'd2, 32'd3, 1'b0, 32'd0);
    step();
    check("add_valid", out_valid, 1);
    check("add_srcA", out_srcA, 5);
    check("add_srcB", out_srcB, 3);
    check("add_op", out_alu_op, 6);
    check("add_dest", out_dest, 4);
    for (int i = 0; i < 4; i++) begin
      drive_op(4'd7, 5'(10 + i), 5'd1, 32'(100 + i), 5'd2, 32'(200 + i), 1'b0, 32'd0);
      step();
      check("b2b_valid", out_valid, 1);
      check("b2b_srcA", out_srcA, 32'(100 + i));
      check("b2b_dest", out_dest, 32'(10 + i));
    end
    idle_inputs();
    step();
    check("b2b_drain", out_valid, 0);

    // stall: MAIN then SKID fill, third op held off
    out_ready = 1'b0;
    drive_op(4'd1, 5'd1, 5'd1, 32'd11, 5'd2, 32'd0, 1'b0, 32'd0);
    step();
    check("stall_in_ready1", in_ready, 1);
    drive_op(4'd2, 5'd2, 5'd1, 32'd12, 5'd2, 32'd0, 1'b0, 32'd0);
    step();
    check("stall_in_ready2", in_ready, 0);
    check("stall_main", out_srcA, 11);
    drive_op(4'd3, 5'd3, 5'd1, 32'd13, 5'd2, 32'd0, 1'b0, 32'd0);
    step();
    check("stall_hold_srcA", out_srcA, 11);
    check("stall_hold_op", out_alu_op, 1);
    check("stall_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    check("drain_op2", out_srcA, 12);
    check("drain_ready", in_ready, 1);
    step();
    check("drain_op3", out_srcA, 13);
    check("drain_op3_dest", out_dest, 3);
    idle_inputs();
    step();
    check("drain_empty", out_valid, 0);

    // capture forwarding, register 0 exclusion, immediate B
    drive_op(4'd6, 5'd5, 5'd7, 32'd1, 5'd7, 32'd2, 1'b1, 32'h55);
    drive_fwd(1'b1, 5'd7, 32'hDEAD);
    step();
    check("capfwd_srcA", out_srcA, 32'hDEAD);
    check("capfwd_imm_B", out_srcB, 32'h55);
    drive_op(4'd6, 5'd5, 5'd0, 32'd1, 5'd0, 32'd2, 1'b0, 32'd0);
    drive_fwd(1'b1, 5'd0, 32'hDEAD);
    step();
    check("capfwd_r0_A", out_srcA, 1);
    check("capfwd_r0_B", out_srcB, 2);
    drive_op(4'd6, 5'd5, 5'd3, 32'd9, 5'd8, 32'd2, 1'b0, 32'd0);
    drive_fwd(1'b1, 5'd8, 32'hBEEF);
    step();
    check("capfwd_B", out_srcB, 32'hBEEF);
    check("capfwd_A_nohit", out_srcA, 9);
    idle_inputs();
    step();

    // snoop into stalled MAIN
    out_ready = 1'b0;
    drive_op(4'd7, 5'd6, 5'd3, 32'h1, 5'd9, 32'h10, 1'b0, 32'd0);
    step();
    check("snoop_pre", out_srcB, 32'h10);
    idle_inputs();
    drive_fwd(1'b1, 5'd9, 32'h20);
    step();
    check("snoop_B", out_srcB, 32'h20);
    check("snoop_op_stable", out_alu_op, 7);
    check("snoop_dest_stable", out_dest, 6);
    drive_fwd(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    step();
    check("snoop_drain", out_valid, 0);

    // immediate-B entry is not snooped; SKID entry is snooped then promoted
    out_ready = 1'b0;
    drive_op(4'd6, 5'd7, 5'd3, 32'h2, 5'd9, 32'h10, 1'b1, 32'h77);
    step();
    drive_op(4'd7, 5'd8, 5'd5, 32'h30, 5'd6, 32'h31, 1'b0, 32'd0);
    drive_fwd(1'b1, 5'd9, 32'h20);
    step();
    check("imm_no_snoop", out_srcB, 32'h77);
    check("imm_skid_full", in_ready, 0);
    idle_inputs();
    drive_fwd(1'b1, 5'd5, 32'h40);
    step();
    check("imm_main_A", out_srcA, 2);
    drive_fwd(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    step();
    check("skid_snoop_A", out_srcA, 32'h40);
    check("skid_B", out_srcB, 32'h31);
    check("skid_dest", out_dest, 8);
    step();
    check("skid_drain", out_valid, 0);

    // flush with MAIN+SKID full and an op offered
    out_ready = 1'b0;
    drive_op(4'd1, 5'd1, 5'd1, 32'hA1, 5'd2, 32'd0, 1'b0, 32'd0);
    step();
    drive_op(4'd2, 5'd2, 5'd1, 32'hA2, 5'd2, 32'd0, 1'b0, 32'd0);
    step();
    drive_op(4'd3, 5'd3, 5'd1, 32'hA3, 5'd2, 32'd0, 1'b0, 32'd0);
    flush = 1'b1;
    step();
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_ghost", out_valid, 0);
    end
    drive_op(4'd4, 5'd9, 5'd1, 32'hB0, 5'd2, 32'd0, 1'b0, 32'd0);
    step();
    check("post_flush_srcA", out_srcA, 32'hB0);
    check("post_flush_valid", out_valid, 1);
    idle_inputs();
    step();

    // asynchronous reset mid-stream with two ops held
    out_ready = 1'b0;
    drive_op(4'd5, 5'd1, 5'd1, 32'hC1, 5'd2, 32'hC2, 1'b0, 32'd0);
    step();
    drive_op(4'd5, 5'd2, 5'd1, 32'hC3, 5'd2, 32'hC4, 1'b0, 32'd0);
    step();
    idle_inputs();
    check("pre_rst_ready", in_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_srcA", out_srcA, 0);
    check("arst_srcB", out_srcB, 0);
    check("arst_op", out_alu_op, 0);
    check("arst_dest", out_dest, 0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
